// File: rtl/ltc2333_sequencer.sv
// ltc2333_sequencer: programs the LTC2333 SoftSpan sequence, then converts and reads back
// one 24-bit word per enabled channel, flagging busy timeouts and channel-order mismatches.
module ltc2333_sequencer #(
    parameter int DIV          = 2,
    parameter int CNV_CYCLES   = 5,
    parameter int CONV_TIMEOUT = 1000,
    parameter int GAP_CYCLES   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  chan_mask,
    input  logic [2:0]  span,
    output logic        ready,
    output logic        cnv,
    output logic        scki,
    output logic        sdi,
    input  logic        busy,
    input  logic        sdo,
    output logic        res_valid,
    output logic [17:0] res_data,
    output logic [2:0]  res_chan,
    output logic [2:0]  res_span,
    output logic        done,
    output logic        err_timeout,
    output logic        err_chan
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CNV  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_HI   = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]  state;
    logic [31:0] cnt;
    logic [6:0]  bcnt;
    logic [6:0]  nbits;
    logic [6:0]  cfg_bits;
    logic [3:0]  pc;
    logic [63:0] tx;
    logic [63:0] cfg_word;
    logic [22:0] rx;
    logic [23:0] word_in;
    logic [7:0]  rem;
    logic        cfg_frame;
    logic [2:0]  exp_chan;

    assign ready    = state == S_IDLE;
    assign word_in  = {rx, sdo};
    assign pc       = 4'($countones(chan_mask));
    assign cfg_bits = pc < 4'd3 ? 7'd24 : {pc, 3'b000};

    // Inserting from the highest channel down leaves the lowest enabled channel in the top byte.
    always_comb begin
        cfg_word = '0;
        for (int i = 7; i >= 0; i--)
            if (chan_mask[i]) cfg_word = {2'b10, 3'(i), span, cfg_word[63:8]};
    end

    // The channel the current data frame should return is the lowest one not yet read.
    always_comb begin
        exp_chan = '0;
        for (int i = 7; i >= 0; i--)
            if (rem[i]) exp_chan = 3'(i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bcnt        <= '0;
            nbits       <= '0;
            tx          <= '0;
            rx          <= '0;
            rem         <= '0;
            cfg_frame   <= 1'b0;
            cnv         <= 1'b0;
            scki        <= 1'b0;
            sdi         <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_chan    <= '0;
            res_span    <= '0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_chan    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    err_timeout <= 1'b0;
                    err_chan    <= 1'b0;
                    if (chan_mask == 8'd0) begin
                        state <= S_DONE;
                    end else begin
                        rem       <= chan_mask;
                        cfg_frame <= 1'b1;
                        tx        <= cfg_word;
                        nbits     <= cfg_bits;
                        cnt       <= '0;
                        cnv       <= 1'b1;
                        state     <= S_CNV;
                    end
                end
                S_CNV: if (cnt == CNV_CYCLES - 1) begin
                    cnv   <= 1'b0;
                    cnt   <= '0;
                    state <= S_WAIT;
                end else begin
                    cnt <= cnt + 1;
                end
                // BUSY is not trusted for the first two cycles while the ADC raises it.
                S_WAIT: if (cnt >= 2 && !busy) begin
                    sdi   <= tx[63];
                    tx    <= {tx[62:0], 1'b0};
                    bcnt  <= cfg_frame ? nbits : 7'd24;
                    cnt   <= '0;
                    state <= S_LO;
                end else if (cnt == CONV_TIMEOUT - 1) begin
                    err_timeout <= 1'b1;
                    cnv         <= 1'b0;
                    scki        <= 1'b0;
                    state       <= S_DONE;
                end else begin
                    cnt <= cnt + 1;
                end
                S_LO: if (cnt == DIV - 1) begin
                    scki  <= 1'b1;
                    cnt   <= '0;
                    state <= S_HI;
                end else begin
                    cnt <= cnt + 1;
                end
                S_HI: if (cnt == DIV - 1) begin
                    scki <= 1'b0;
                    cnt  <= '0;
                    rx   <= word_in[22:0];
                    bcnt <= bcnt - 7'd1;
                    if (bcnt == 7'd1) begin
                        sdi       <= 1'b0;
                        cfg_frame <= 1'b0;
                        state     <= S_GAP;
                        if (!cfg_frame) begin
                            res_valid                      <= 1'b1;
                            {res_data, res_chan, res_span} <= word_in;
                            err_chan                       <= err_chan | (word_in[5:3] != exp_chan);
                            rem[exp_chan]                  <= 1'b0;
                        end
                    end else begin
                        sdi   <= tx[63];
                        tx    <= {tx[62:0], 1'b0};
                        state <= S_LO;
                    end
                end else begin
                    cnt <= cnt + 1;
                end
                S_GAP: if (cnt == GAP_CYCLES - 1) begin
                    cnt <= '0;
                    if (rem == 8'd0) begin
                        state <= S_DONE;
                    end else begin
                        cnv   <= 1'b1;
                        state <= S_CNV;
                    end
                end else begin
                    cnt <= cnt + 1;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ltc2333_sequencer.sv
// tb_ltc2333_sequencer: behavioural LTC2333 model plus scoreboard for the sequencer.
module tb_ltc2333_sequencer;
    localparam int CT = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  chan_mask = '0;
    logic [2:0]  span = '0;
    logic        ready, cnv, scki, sdi, res_valid, done, err_timeout, err_chan;
    logic        busy = 1'b0;
    logic        sdo;
    logic [17:0] res_data;
    logic [2:0]  res_chan, res_span;

    ltc2333_sequencer #(.DIV(2), .CNV_CYCLES(5), .CONV_TIMEOUT(CT), .GAP_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .chan_mask(chan_mask), .span(span),
        .ready(ready), .cnv(cnv), .scki(scki), .sdi(sdi), .busy(busy), .sdo(sdo),
        .res_valid(res_valid), .res_data(res_data), .res_chan(res_chan), .res_span(res_span),
        .done(done), .err_timeout(err_timeout), .err_chan(err_chan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ch;
        logic [2:0] sp;
    } exp_t;

    int tests = 0;
    int fails = 0;
    exp_t        exp_q[$];
    logic [17:0] data_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ADC model: learns its channel sequence from any SDI frame starting with a 1,
    // returns {data, channel, span} per conversion in that programmed order.
    logic [23:0] word = '0;
    int          idx = 24;
    logic [63:0] cap = '0;
    int          ncap = 0;
    logic        first_bit = 1'b0;
    logic [63:0] cfg_cap = '0;
    int          cfg_n = 0;
    logic [7:0]  seq[$];
    int          sidx = 0;
    int          adc_frame = 0;
    int          cnv_rises = 0;
    bit          force_busy = 1'b0;
    int          corrupt_from = -1;
    int          corrupt_to = 0;
    logic [63:0] pt;
    logic [7:0]  pe;
    logic [2:0]  pch;
    logic [17:0] pd;

    always @(posedge cnv) begin
        cnv_rises++;
        busy = 1'b1;
        if (ncap > 0 && first_bit) begin
            cfg_cap = cap;
            cfg_n = ncap;
            seq.delete();
            for (int b = 0; b < ncap / 8; b++) begin
                pt = cap >> (ncap - 8 * (b + 1));
                if (pt[7]) seq.push_back(pt[7:0]);
            end
            sidx = 0;
        end
        ncap = 0;
        cap = '0;
        pe = seq.size() > 0 ? seq[sidx % seq.size()] : 8'h00;
        sidx++;
        pch = pe[5:3];
        if (adc_frame > 0 && int'(pch) == corrupt_from) begin
            pch = 3'(corrupt_to);
            corrupt_from = -1;
        end
        pd = 18'($urandom);
        word = {pd, pch, pe[2:0]};
        if (adc_frame > 0) data_q.push_back(pd);
        adc_frame++;
        idx = 0;
    end

    always @(negedge cnv) begin
        repeat ($urandom_range(3, 15)) @(posedge clk);
        if (!force_busy) busy = 1'b0;
    end

    always @(posedge scki) begin
        if (ncap == 0) first_bit = sdi;
        if (ncap < 64) begin
            cap = {cap[62:0], sdi};
            ncap++;
        end
    end

    always @(negedge scki) idx++;

    always_comb begin
        sdo = 1'b0;
        if (idx < 24) sdo = word[23 - idx];
    end

    // Monitor: every res_valid is matched against the oldest expected result.
    int   done_cnt = 0;
    exp_t m_e;
    logic [17:0] m_d;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got chan %0d data %0h, required no result", res_chan, res_data);
            end else begin
                m_e = exp_q.pop_front();
                chk("res_chan", 64'(res_chan), 64'(m_e.ch));
                chk("res_span", 64'(res_span), 64'(m_e.sp));
                if (data_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL res_data: got %0h, required a converted sample (none pending)", res_data);
                end else begin
                    m_d = data_q.pop_front();
                    chk("res_data", 64'(res_data), 64'(m_d));
                end
            end
        end
    end

    task automatic issue(input logic [7:0] m, input logic [2:0] s);
        exp_t e;
        for (int i = 0; i < 8; i++)
            if (m[i]) begin
                e.ch = (i == corrupt_from) ? 3'(corrupt_to) : 3'(i);
                e.sp = s;
                exp_q.push_back(e);
            end
        adc_frame = 0;
        cnv_rises = 0;
        done_cnt = 0;
        cfg_n = 0;
        @(negedge clk);
        start = 1'b1;
        chan_mask = m;
        span = s;
        @(negedge clk);
        start = 1'b0;
        chk("ready_after_start", 64'(ready), 64'd0);
        chk("err_chan_cleared", 64'(err_chan), 64'd0);
        chk("err_timeout_cleared", 64'(err_timeout), 64'd0);
    endtask

    task automatic finish_seq(input logic [7:0] m, input logic [2:0] s, input logic exp_err);
        int c;
        int n;
        logic [63:0] val;
        int nb;
        c = 0;
        while (!done && c < 6000) begin
            @(negedge clk);
            c++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_wait: got no done after %0d cycles, required done", c);
        end
        @(negedge clk);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("ready_end", 64'(ready), 64'd1);
        n = 0;
        val = '0;
        nb = 0;
        for (int i = 0; i < 8; i++)
            if (m[i]) begin
                n++;
                val = (val << 8) | 64'({2'b10, 3'(i), s});
                nb += 8;
            end
        while (nb < 24) begin
            val = val << 8;
            nb += 8;
        end
        chk("cfg_bits", 64'(cfg_n), 64'(nb));
        chk("cfg_word", cfg_cap, val);
        chk("results_left", 64'(exp_q.size()), 64'd0);
        chk("cnv_count", 64'(cnv_rises), 64'(n + 1));
        chk("err_chan_end", 64'(err_chan), 64'(exp_err));
        chk("err_timeout_end", 64'(err_timeout), 64'd0);
    endtask

    task automatic run(input logic [7:0] m, input logic [2:0] s, input logic exp_err);
        issue(m, s);
        finish_seq(m, s, exp_err);
    endtask

    initial begin
        logic [7:0] rm;
        logic [2:0] rs;
        int c;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_outs", 64'({cnv, scki, sdi, res_valid, done, err_timeout, err_chan}), 64'd0);

        run(8'h01, 3'd7, 1'b0);
        run(8'hFF, 3'd5, 1'b0);
        run(8'hA4, 3'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            rm = 8'($urandom_range(1, 255));
            rs = 3'($urandom);
            run(rm, rs, 1'b0);
        end

        corrupt_from = 2;
        corrupt_to = 3;
        run(8'hA4, 3'd3, 1'b1);
        corrupt_from = -1;
        run(8'($urandom_range(1, 255)), 3'($urandom), 1'b0);

        // BUSY stuck high from the second conversion onwards.
        issue(8'h03, 3'd1);
        c = 0;
        while (cnv_rises < 2 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        force_busy = 1'b1;
        c = 0;
        while (cnv && c < 20) begin
            @(negedge clk);
            c++;
        end
        c = 0;
        while (!err_timeout && c < CT + 50) begin
            @(negedge clk);
            c++;
        end
        chk("timeout_latency", 64'(c), 64'(CT));
        chk("timeout_cnv_scki", 64'({cnv, scki}), 64'd0);
        @(negedge clk);
        chk("timeout_done", 64'(done), 64'd1);
        chk("timeout_ready", 64'(ready), 64'd1);
        chk("timeout_sticky", 64'(err_timeout), 64'd1);
        chk("timeout_no_result", 64'(exp_q.size()), 64'd2);
        exp_q.delete();
        data_q.delete();
        force_busy = 1'b0;
        busy = 1'b0;

        issue(8'h00, 3'd0);
        chk("mask0_done_early", 64'(done), 64'd0);
        @(negedge clk);
        chk("mask0_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("mask0_no_cnv", 64'(cnv_rises), 64'd0);
        chk("mask0_ready", 64'(ready), 64'd1);

        // Reset landing while scki is high in the first data frame.
        issue(8'h05, 3'd2);
        c = 0;
        while (!(cnv_rises == 2 && scki) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_outs", 64'({cnv, scki, sdi, res_valid, done, err_timeout, err_chan}), 64'd0);
        chk("midreset_data", 64'({res_data, res_chan, res_span}), 64'd0);
        chk("midreset_ready", 64'(ready), 64'd1);
        exp_q.delete();
        data_q.delete();
        run(8'h01, 3'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ltc2333_sequencer.md
# ltc2333_sequencer

Controller that drives the LTC2333 8-channel 18-bit SAR ADC serial interface (CNV, SCKI, SDI, BUSY, SDO) from the fabric clock. On a start request it programs the ADC's SoftSpan sequence for a mask of channels, then runs one conversion and readout per enabled channel. Each 24-bit readout word is parsed into data, channel and span fields and presented on a valid-strobe result port. It sits between the ADC pins and the DAQ readout FIFO.

## Interface
- DIV, 2: SCKI half-period in clk cycles (≥1).
- CNV_CYCLES, 5: CNV high-pulse width in clk cycles (≥1).
- CONV_TIMEOUT, 1000: maximum clk cycles to wait for BUSY low after CNV falls.
- GAP_CYCLES, 10: idle clk cycles between end of a readout frame and the next CNV.

- clk  in  1  fabric clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a sequence; sampled only in IDLE.
- chan_mask  in  8  enabled channels; bit n = channel n; captured at start.
- span  in  3  SoftSpan code applied to all enabled channels; captured at start.
- ready  out  1  high in IDLE.
- cnv  out  1  ADC convert strobe.
- scki  out  1  ADC serial clock; idles low.
- sdi  out  1  ADC config data.
- busy  in  1  ADC conversion in progress.
- sdo  in  1  ADC serial data.
- res_valid  out  1  one-cycle strobe, result fields valid.
- res_data  out  18  conversion result, word bits [23:6].
- res_chan  out  3  channel ID, word bits [5:3].
- res_span  out  3  SoftSpan ID, word bits [2:0].
- done  out  1  one-cycle strobe at sequence end, normal or aborted.
- err_timeout  out  1  sticky; cleared at next accepted start.
- err_chan  out  1  sticky; res_chan ≠ expected channel; cleared at next accepted start.

## Operation
- States: IDLE, CNV_HI, CONV_WAIT, SHIFT_LO, SHIFT_HI, GAP, DONE.
- N = popcount(chan_mask). Enabled channels are sequenced in ascending index order.
- start in IDLE with chan_mask = 0: goes to DONE, no CNV issued.
- start in IDLE with chan_mask ≠ 0: latch mask and span, clear error flags, begin frame 0.
- start outside IDLE is ignored.
- **Frame 0 (config):**
  - CNV pulse, then wait for BUSY low.
  - Shift 8·max(N,3) bits, MSB first.
  - One config byte per enabled channel, ascending: bit7 = 1, bit6 = 0, [5:3] = channel, [2:0] = span.
  - Remaining bytes are 0x00.
  - SDO data in this frame is discarded.
- **Frames 1..N (data):**
  - CNV pulse, wait for BUSY low, shift 24 bits with sdi = 0.
  - Emit one result per frame.
  - Frame k is expected to return the k-th enabled channel. A mismatch sets err_chan but the result is still emitted.
- After frame N completes its GAP: go to DONE (done = 1 for one cycle), then IDLE.
- **Timeout:** if BUSY is still high after CONV_TIMEOUT cycles in CONV_WAIT, set err_timeout, drive cnv = scki = 0 and abort to DONE. No result is emitted for that frame.
- **Reset:** takes effect at any point, including mid-frame.
  - Next clock: state = IDLE, cnv = scki = sdi = 0, res_valid = done = 0, errors = 0, ready = 1.

## Timing
- start accepted at edge t: cnv = 1 from t+1 for CNV_CYCLES cycles.
- CONV_WAIT is entered when cnv falls. BUSY is ignored for the first 2 cycles (ADC BUSY rise latency).
- BUSY low sampled in CONV_WAIT: next cycle enters SHIFT_LO.
- **Bit cell = 2·DIV cycles:**
  - SHIFT_LO: scki = 0 for DIV cycles. sdi is updated on entry to SHIFT_LO, giving DIV cycles of setup.
  - SHIFT_HI: scki = 1 for DIV cycles. sdo is sampled on the last clk of SHIFT_HI, then scki falls.
- Result frame of 24 bits = 48·DIV cycles. res_valid asserts the cycle after the 24th sample.
- Result fields hold until the next res_valid.
- GAP: scki = 0, sdi = 0 for GAP_CYCLES cycles, then next CNV.
- Per-channel throughput = CNV_CYCLES + conversion time + 48·DIV + GAP_CYCLES + 2 cycles.

## Test plan
- mask = 0x01, span = 7: SDI frame 0 carries 0x870000 (24 bits). One result follows with res_chan = 0, res_span = 7. res_data equals the model value. done fires once.
- mask = 0xFF, span = 5: frame 0 carries 64 bits 0x858D959DA5ADB5BD. Eight results follow with res_chan 0..7 in order. err_chan = 0.
- mask = 0xA4, span = 3: frame 0 carries 0x93AB BB… i.e. bytes 0x93, 0xAB, 0xBB. Three results follow with channels 2, 5, 7.
- BUSY forced high after the second CNV: err_timeout = 1 exactly CONV_TIMEOUT cycles after cnv falls. cnv = scki = 0, done pulses, ready returns to 1.
- Model corrupted to return channel 3 when 2 is expected: result is emitted with res_chan = 3 and err_chan = 1. A subsequent start clears err_chan.
- reset asserted mid-SHIFT_HI of frame 1: next cycle all outputs are at reset values. A new start with mask 0x01 completes normally.
- mask = 0x00: done pulses 2 cycles after start. cnv never rises.
